// File: rtl/cam_wr_packer.sv
// Packs camera bytes into 16-bit words for the SDRAM write FIFO and pads each
// frame with PAD_DATA up to a whole number of write bursts.
module cam_wr_packer #(
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned LOAD_CYCLES = 4,
    parameter logic [15:0] PAD_DATA    = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic        FRAME_START,
    input  logic        FRAME_END,
    input  logic        PIX_VALID,
    input  logic [7:0]  PIX_DATA,
    input  logic        WR_FULL,
    output logic [15:0] WR_DATA,
    output logic        WR,
    output logic        WR_LOAD,
    output logic        FRAME_DONE,
    output logic        OVERFLOW,
    output logic [21:0] WORD_CNT
);
    localparam int unsigned LoadLast = (LOAD_CYCLES > 0) ? LOAD_CYCLES - 1 : 0;
    localparam int unsigned LoadW    = (LoadLast > 0) ? $clog2(LoadLast + 1) : 1;
    localparam logic [21:0] BurstLen = 22'((BURST_LEN > 0) ? BURST_LEN : 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StLoad,
        StCapture,
        StPad,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [LoadW-1:0]   load_cnt_q, load_cnt_d;
    logic               phase_q, phase_d;
    logic [7:0]         byte_q, byte_d;
    logic               wr_q, wr_d;
    logic [15:0]        wr_data_q, wr_data_d;
    logic               overflow_q, overflow_d;
    logic [21:0]        word_cnt_q, word_cnt_d;

    logic               issue;
    logic [15:0]        issue_data;
    logic               cnt_sat;
    logic               burst_aligned;

    assign cnt_sat       = &word_cnt_q;
    assign burst_aligned = (word_cnt_q % BurstLen) == 22'd0;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        phase_d    = phase_q;
        byte_d     = byte_q;
        wr_d       = 1'b0;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;
        word_cnt_d = word_cnt_q;
        issue      = 1'b0;
        issue_data = wr_data_q;

        unique case (state_q)
            StIdle: begin
                if (ENABLE) state_d = StArm;
            end
            StArm: begin
                if (!ENABLE)          state_d = StIdle;
                else if (FRAME_START) state_d = StLoad;
            end
            StLoad: begin
                if (load_cnt_q == LoadW'(LoadLast)) state_d = StCapture;
                else                                load_cnt_d = load_cnt_q + LoadW'(1);
            end
            StCapture: begin
                if (FRAME_START) begin
                    state_d = StLoad;
                end else begin
                    if (PIX_VALID) begin
                        if (phase_q) begin
                            issue      = 1'b1;
                            issue_data = {byte_q, PIX_DATA};
                            phase_d    = 1'b0;
                        end else begin
                            phase_d = 1'b1;
                            byte_d  = PIX_DATA;
                        end
                    end
                    // A byte arriving with FRAME_END is taken first, so the flush
                    // sees the phase after that byte.
                    if (FRAME_END) begin
                        if (phase_d) begin
                            issue      = 1'b1;
                            issue_data = {byte_d, 8'h00};
                            phase_d    = 1'b0;
                        end
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                if (FRAME_START) begin
                    state_d = StLoad;
                end else if (burst_aligned || cnt_sat) begin
                    state_d = StDone;
                end else if (!WR_FULL) begin
                    issue      = 1'b1;
                    issue_data = PAD_DATA;
                end
            end
            StDone: begin
                state_d = ENABLE ? StArm : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (issue) begin
            if (WR_FULL) begin
                overflow_d = 1'b1;
            end else begin
                wr_d      = 1'b1;
                wr_data_d = issue_data;
                if (!cnt_sat) word_cnt_d = word_cnt_q + 22'd1;
            end
        end

        if (state_d == StLoad && state_q != StLoad) begin
            load_cnt_d = '0;
            phase_d    = 1'b0;
            overflow_d = 1'b0;
            word_cnt_d = '0;
            wr_d       = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            phase_q    <= 1'b0;
            byte_q     <= 8'h00;
            wr_q       <= 1'b0;
            wr_data_q  <= 16'h0000;
            overflow_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            phase_q    <= phase_d;
            byte_q     <= byte_d;
            wr_q       <= wr_d;
            wr_data_q  <= wr_data_d;
            overflow_q <= overflow_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign WR         = wr_q;
    assign WR_DATA    = wr_data_q;
    assign WR_LOAD    = (state_q == StLoad);
    assign FRAME_DONE = (state_q == StDone);
    assign OVERFLOW   = overflow_q;
    assign WORD_CNT   = word_cnt_q;

endmodule

// File: tb/tb_cam_wr_packer.sv
// Bench for cam_wr_packer: directed corner cases plus random frames checked
// against a model that derives the word stream from the list of accepted bytes.
module tb_cam_wr_packer;
    localparam int unsigned BurstLen   = 4;
    localparam int unsigned LoadCycles = 4;
    localparam logic [15:0] PadData    = 16'h0000;

    typedef logic [7:0]  bytes_t[$];
    typedef logic [15:0] words_t[$];

    logic        CLK         = 1'b0;
    logic        RESET_N     = 1'b1;
    logic        ENABLE      = 1'b0;
    logic        FRAME_START = 1'b0;
    logic        FRAME_END   = 1'b0;
    logic        PIX_VALID   = 1'b0;
    logic [7:0]  PIX_DATA    = 8'h00;
    logic        WR_FULL     = 1'b0;
    logic [15:0] WR_DATA;
    logic        WR;
    logic        WR_LOAD;
    logic        FRAME_DONE;
    logic        OVERFLOW;
    logic [21:0] WORD_CNT;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    int exp_done = 0;
    int exp_load = 0;
    logic [15:0] got[$];

    always #5 CLK = ~CLK;

    cam_wr_packer #(
        .BURST_LEN  (BurstLen),
        .LOAD_CYCLES(LoadCycles),
        .PAD_DATA   (PadData)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .ENABLE     (ENABLE),
        .FRAME_START(FRAME_START),
        .FRAME_END  (FRAME_END),
        .PIX_VALID  (PIX_VALID),
        .PIX_DATA   (PIX_DATA),
        .WR_FULL    (WR_FULL),
        .WR_DATA    (WR_DATA),
        .WR         (WR),
        .WR_LOAD    (WR_LOAD),
        .FRAME_DONE (FRAME_DONE),
        .OVERFLOW   (OVERFLOW),
        .WORD_CNT   (WORD_CNT)
    );

    always @(negedge CLK) begin
        if (WR) got.push_back(WR_DATA);
        if (WR_LOAD) load_cnt++;
        if (FRAME_DONE) done_cnt++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pair bytes high-first, flush an odd byte with 00, then pad to a burst multiple.
    function automatic words_t model(input bytes_t b);
        words_t w;
        for (int i = 0; i + 1 < b.size(); i += 2) w.push_back({b[i], b[i+1]});
        if (b.size() % 2 == 1) w.push_back({b[b.size()-1], 8'h00});
        while (w.size() % BurstLen != 0) w.push_back(PadData);
        return w;
    endfunction

    task automatic start_frame(input string tag);
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        exp_load += LoadCycles;
        check({tag, "_wr_load"}, 32'(WR_LOAD), 32'd1);
        check({tag, "_cnt_clr"}, 32'(WORD_CNT), 32'd0);
        check({tag, "_ovf_clr"}, 32'(OVERFLOW), 32'd0);
        // Bytes offered while loading must be ignored.
        for (int i = 0; i < LoadCycles; i++) begin
            PIX_VALID = 1'($urandom_range(1, 0));
            PIX_DATA  = 8'($urandom);
            step();
        end
        PIX_VALID = 1'b0;
    endtask

    // end_mode: 0 none, 1 separate FRAME_END pulse, 2 FRAME_END with the last byte.
    task automatic send_bytes(input bytes_t b, input int gap_max, input int end_mode);
        for (int i = 0; i < b.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                PIX_DATA = 8'($urandom);
                step();
            end
            PIX_VALID = 1'b1;
            PIX_DATA  = b[i];
            FRAME_END = (end_mode == 2) && (i == b.size() - 1);
            step();
            PIX_VALID = 1'b0;
        end
        if (end_mode != 0 && !FRAME_END) begin
            FRAME_END = 1'b1;
            step();
        end
        FRAME_END = 1'b0;
    endtask

    task automatic wait_done(input bit stall, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            WR_FULL = stall ? 1'($urandom_range(1, 0)) : 1'b0;
            step();
            seen = FRAME_DONE;
        end
        WR_FULL = 1'b0;
        exp_done++;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        step();
        check({tag, "_done_pulse"}, 32'(FRAME_DONE), 32'd0);
    endtask

    task automatic compare(input words_t exp, input string tag);
        check({tag, "_nwords"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        check({tag, "_word_cnt"}, 32'(WORD_CNT), 32'(exp.size()));
        check({tag, "_frames_done"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "_load_cycles"}, 32'(load_cnt), 32'(exp_load));
    endtask

    task automatic run_frame(input bytes_t b, input int gap_max, input int end_mode,
                             input bit stall, input string tag);
        got.delete();
        start_frame(tag);
        send_bytes(b, gap_max, end_mode);
        wait_done(stall, tag);
        compare(model(b), tag);
    endtask

    initial begin
        bytes_t b;
        words_t w;
        int     n;

        #2 RESET_N = 1'b0;
        #1;
        check("reset_wr", 32'(WR), 32'd0);
        check("reset_wr_load", 32'(WR_LOAD), 32'd0);
        check("reset_done", 32'(FRAME_DONE), 32'd0);
        check("reset_ovf", 32'(OVERFLOW), 32'd0);
        check("reset_cnt", 32'(WORD_CNT), 32'd0);
        check("reset_data", 32'(WR_DATA), 32'd0);
        repeat (2) step();
        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        step();

        b.delete();
        for (int i = 1; i <= 8; i++) b.push_back(8'(i));
        run_frame(b, 0, 1, 1'b0, "basic");

        b.delete();
        b.push_back(8'hAA); b.push_back(8'hBB); b.push_back(8'hCC);
        run_frame(b, 0, 1, 1'b0, "odd_pad");

        b.delete();
        b.push_back(8'h5A); b.push_back(8'hC3); b.push_back(8'h7E);
        run_frame(b, 1, 2, 1'b0, "coincide");

        b.delete();
        run_frame(b, 0, 1, 1'b0, "empty");

        // Second word meets a full FIFO and is dropped.
        got.delete();
        b.delete();
        for (int i = 1; i <= 8; i++) b.push_back(8'(i));
        start_frame("ovf");
        for (int i = 0; i < 8; i++) begin
            PIX_VALID = 1'b1;
            PIX_DATA  = b[i];
            WR_FULL   = (i == 3);
            step();
        end
        PIX_VALID = 1'b0;
        WR_FULL   = 1'b0;
        check("ovf_cnt_before_pad", 32'(WORD_CNT), 32'd3);
        check("ovf_flag", 32'(OVERFLOW), 32'd1);
        send_bytes(bytes_t'{}, 0, 1);
        wait_done(1'b0, "ovf");
        w.delete();
        w.push_back(16'h0102); w.push_back(16'h0506); w.push_back(16'h0708);
        w.push_back(PadData);
        compare(w, "ovf");
        check("ovf_sticky", 32'(OVERFLOW), 32'd1);

        // FIFO full for five cycles while padding.
        got.delete();
        b.delete();
        b.push_back(8'h11); b.push_back(8'h22); b.push_back(8'h33);
        start_frame("stall");
        send_bytes(b, 0, 1);
        WR_FULL = 1'b1;
        repeat (5) step();
        check("stall_words_held", 32'(got.size()), 32'd2);
        check("stall_wr_low", 32'(WR), 32'd0);
        check("stall_cnt", 32'(WORD_CNT), 32'd2);
        WR_FULL = 1'b0;
        wait_done(1'b0, "stall");
        compare(model(b), "stall");

        // Abort after three words, then complete the restarted frame.
        got.delete();
        b.delete();
        for (int i = 0; i < 6; i++) b.push_back(8'(8'h31 + i));
        start_frame("abort");
        send_bytes(b, 0, 0);
        step();
        check("abort_cnt_before", 32'(WORD_CNT), 32'd3);
        start_frame("abort_restart");
        got.delete();
        b.delete();
        for (int i = 0; i < 8; i++) b.push_back(8'(8'h41 + i));
        send_bytes(b, 0, 1);
        wait_done(1'b0, "abort");
        compare(model(b), "abort");

        // ENABLE low in ARM: FRAME_START is ignored.
        ENABLE = 1'b0;
        step();
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        step();
        check("disarm_no_load", 32'(WR_LOAD), 32'd0);
        check("disarm_load_cycles", 32'(load_cnt), 32'(exp_load));
        ENABLE = 1'b1;
        step();

        // ENABLE dropped mid-frame: frame completes, then the block idles.
        got.delete();
        b.delete();
        for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
        start_frame("en_drop");
        ENABLE = 1'b0;
        send_bytes(b, 1, 2);
        wait_done(1'b1, "en_drop");
        compare(model(b), "en_drop");
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        step();
        check("en_drop_idle", 32'(WR_LOAD), 32'd0);
        ENABLE = 1'b1;
        step();

        for (int f = 0; f < 8; f++) begin
            b.delete();
            n = int'($urandom_range(13, 0));
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            run_frame(b, int'($urandom_range(2, 0)), int'($urandom_range(2, 1)), 1'b1,
                      $sformatf("rand%0d", f));
        end

        // Asynchronous reset while a word is on the bus.
        got.delete();
        start_frame("rst");
        PIX_VALID = 1'b1;
        PIX_DATA  = 8'h21;
        step();
        PIX_DATA  = 8'h22;
        step();
        PIX_VALID = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        check("rst_mid_wr", 32'(WR), 32'd0);
        check("rst_mid_data", 32'(WR_DATA), 32'd0);
        check("rst_mid_cnt", 32'(WORD_CNT), 32'd0);
        check("rst_mid_load", 32'(WR_LOAD), 32'd0);
        check("rst_mid_done", 32'(FRAME_DONE), 32'd0);
        check("rst_mid_ovf", 32'(OVERFLOW), 32'd0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            PIX_VALID = 1'b1;
            PIX_DATA  = 8'($urandom);
            FRAME_END = (i == 5);
            step();
        end
        PIX_VALID = 1'b0;
        FRAME_END = 1'b0;
        check("rst_no_wr", 32'(got.size()), 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'(exp_done));
        check("rst_cnt_idle", 32'(WORD_CNT), 32'd0);

        b.delete();
        for (int i = 0; i < 7; i++) b.push_back(8'($urandom));
        run_frame(b, 1, 1, 1'b1, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_wr_packer.md
CAM_WR_PACKER -- requirements
Module: cam_wr_packer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256: write burst length in words; must equal the SDRAM write-side length setting.
REQ-002 SHALL have parameter LOAD_CYCLES, default 4: number of cycles WR_LOAD is held high per frame.
REQ-003 SHALL have parameter PAD_DATA, default 16'h0000: word value written during end-of-frame padding.
REQ-004 SHALL have port CLK  in  1  clock; also used as the write-FIFO write clock.
REQ-005 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ENABLE  in  1  arms capture of the next frame.
REQ-007 SHALL have port FRAME_START  in  1  one-cycle pulse marking the start of a frame.
REQ-008 SHALL have port FRAME_END  in  1  one-cycle pulse marking the end of a frame.
REQ-009 SHALL have port PIX_VALID  in  1  PIX_DATA is valid in this cycle.
REQ-010 SHALL have port PIX_DATA  in  8  pixel byte.
REQ-011 SHALL have port WR_FULL  in  1  write FIFO full.
REQ-012 SHALL have port WR_DATA  out  16  packed word to the write FIFO.
REQ-013 SHALL have port WR  out  1  write FIFO write request.
REQ-014 SHALL have port WR_LOAD  out  1  write-address reload and FIFO clear.
REQ-015 SHALL have port FRAME_DONE  out  1  one-cycle pulse when a frame has been fully written.
REQ-016 SHALL have port OVERFLOW  out  1  sticky flag: a word was dropped in the current frame.
REQ-017 SHALL have port WORD_CNT  out  22  number of words written in the current frame.

Function
REQ-018 SHALL implement FSM states IDLE, ARM, LOAD, CAPTURE, PAD, DONE.
REQ-019 SHALL move IDLE->ARM when ENABLE=1, and ARM->IDLE when ENABLE=0.
REQ-020 SHALL move ARM->LOAD on FRAME_START.
REQ-021 SHALL, in LOAD, drive WR_LOAD=1 for exactly LOAD_CYCLES cycles, clear WORD_CNT, OVERFLOW and the byte phase, then enter CAPTURE.
REQ-022 SHALL ignore PIX_VALID in IDLE, ARM and LOAD; those bytes are neither packed nor counted.
REQ-023 SHALL, in CAPTURE, place the first accepted byte in WR_DATA[15:8] and the second in WR_DATA[7:0].
REQ-024 SHALL register WR_DATA and pulse WR=1 for one cycle, on the cycle after the edge that accepts the second byte (latency 1 cycle).
REQ-025 SHALL, when a word is due and WR_FULL=1, drop that word: WR stays 0, OVERFLOW is set, WORD_CNT is not incremented, and the byte phase resets.
REQ-026 SHALL increment WORD_CNT by 1 on every cycle with WR=1; WORD_CNT saturates at 22'h3FFFFF.
REQ-027 SHALL, on FRAME_END in CAPTURE with one byte pending, write {pending,8'h00} as a normal word, then enter PAD.
REQ-028 SHALL, on FRAME_END in CAPTURE with no byte pending, enter PAD directly.
REQ-029 SHALL, when PIX_VALID and FRAME_END coincide, accept the byte first, then apply the FRAME_END rules.
REQ-030 SHALL, in PAD, write PAD_DATA one word per cycle while WR_FULL=0 and stall without dropping while WR_FULL=1.
REQ-031 SHALL leave PAD for DONE once WORD_CNT mod BURST_LEN == 0; a count already aligned (including 0) writes no pad.
REQ-032 SHALL, in DONE, pulse FRAME_DONE for one cycle, then go to ARM if ENABLE=1, else IDLE.
REQ-033 SHALL, on FRAME_START in CAPTURE or PAD, abort the current frame without FRAME_DONE and go to LOAD.
REQ-034 SHALL take ENABLE=0 into effect only in ARM; LOAD, CAPTURE and PAD run to completion.
REQ-035 SHALL hold OVERFLOW until the next LOAD entry or reset.

Reset
REQ-036 SHALL, on RESET_N=0 at any time, asynchronously force state=IDLE, WR=0, WR_LOAD=0, FRAME_DONE=0, OVERFLOW=0, WORD_CNT=0, WR_DATA=16'h0000, byte phase=0.
REQ-037 SHALL, after a reset during CAPTURE, issue no pad and no FRAME_DONE; the next frame needs ENABLE and a fresh FRAME_START.

Verification
REQ-038 Basic frame, BURST_LEN=4: ENABLE=1, FRAME_START, bytes 01..08, FRAME_END -> WR_LOAD high 4 cycles; words 0102,0304,0506,0708; no pad; WORD_CNT=4; one FRAME_DONE.
REQ-039 Odd byte with pad, BURST_LEN=4: bytes AA,BB,CC, FRAME_END -> words AABB, CC00, 0000, 0000; WORD_CNT=4; FRAME_DONE.
REQ-040 Overflow: WR_FULL=1 when the second word is due in a 4-word frame -> that word is dropped; OVERFLOW=1; WORD_CNT=3 before pad, then pad to 4; OVERFLOW clears at the next LOAD.
REQ-041 Pad stall: WR_FULL=1 for 5 cycles during PAD -> WR=0 for those cycles; no pad word lost; final WORD_CNT is a multiple of BURST_LEN.
REQ-042 Abort: FRAME_START after 3 words -> no FRAME_DONE; WR_LOAD reasserts; WORD_CNT=0.
REQ-043 Reset mid-CAPTURE: RESET_N low for 1 cycle -> all outputs take their reset values immediately; no WR until ENABLE and a new FRAME_START.
